// File: rtl/rr_request_arbiter_pkg.sv
// Shared constants, FSM state type and index helper for the 8-way round-robin arbiter.
package rr_request_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int TMO_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_request_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_request_arbiter_if;
  import rr_request_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_request_arbiter_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping 7->0.
module rr_priority_pick
  import rr_request_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] ffs;

  // Rotate so that bit ptr lands at position 0; index arithmetic wraps in IDX_W bits.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + ptr];
    end
  end

  always_comb begin
    ffs = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) ffs = IDX_W'(i);
    end
  end

  assign pick_idx = ffs + ptr;
  assign any      = |req;

endmodule

// File: rtl/rr_request_arbiter.sv
// Round-robin arbiter: one registered one-hot grant held until done, withdrawal or watchdog expiry.
module rr_request_arbiter
  import rr_request_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  rr_request_arbiter_if.slave bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [TMO_W-1:0] cnt;
  logic [IDX_W-1:0] pick_idx;
  logic             any;
  logic             rel_owner;
  logic             rel_wdog;

  logic [N_REQ-1:0] grant_p1;
  logic             gvld_p1;
  logic             tmo_p1;

  rr_priority_pick u_pick (
    .req      (bus.req),
    .ptr      (ptr),
    .pick_idx (pick_idx),
    .any      (any)
  );

  // Owner-driven release (done or withdrawal) takes precedence over the watchdog.
  assign rel_owner = bus.done || ((bus.req & grant_p1) == '0);
  assign rel_wdog  = (TIMEOUT != 0) && (cnt == TMO_LAST);

  // Stage p1: FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      cnt      <= '0;
      grant_p1 <= '0;
      gvld_p1  <= 1'b0;
      tmo_p1   <= 1'b0;
    end else begin
      tmo_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant_p1 <= idx2onehot(pick_idx);
            gidx     <= pick_idx;
            gvld_p1  <= 1'b1;
            cnt      <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rel_owner || rel_wdog) begin
            grant_p1 <= '0;
            gvld_p1  <= 1'b0;
            ptr      <= gidx + IDX_W'(1);
            tmo_p1   <= ~rel_owner;
            state    <= IDLE;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_p1;
  assign bus.gnt_valid = gvld_p1;
  assign bus.timeout   = tmo_p1;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Scoreboard bench for rr_request_arbiter: directed scenarios plus randomized traffic vs a cycle model.
module tb_rr_request_arbiter;
  import rr_request_arbiter_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    logic [7:0] g;
    logic       t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rr_request_arbiter_if bus ();

  rr_request_arbiter #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: owner index (-1 when idle), next search start, grant cycles elapsed.
  int m_owner = -1;
  int m_next  = 0;
  int m_held  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_next  = 0;
    m_held  = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    exp_t e;
    bit   rel_own;
    bit   rel_wd;
    e.t = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_next + k) % 8;
        if (r[idx] && m_owner < 0) begin
          m_owner = idx;
          m_held  = 0;
        end
      end
    end else begin
      m_held++;
      rel_own = d || !r[m_owner];
      rel_wd  = (TMO != 0) && (m_held == TMO);
      if (rel_own || rel_wd) begin
        m_next  = (m_owner + 1) % 8;
        m_owner = -1;
        e.t     = !rel_own;
      end
    end
    e.g = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus; returns shortly after the edge that consumes it.
  task automatic step(input logic [7:0] r, input logic d);
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    model_step(r, d);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_gnt_valid", 32'(bus.gnt_valid), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: invariants every cycle, scoreboard pop whenever a prediction is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("onehot0", 32'($onehot0(bus.grant)), 32'h1);
      chk("gnt_valid_or", 32'(bus.gnt_valid), 32'(|bus.grant));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("grant", 32'(bus.grant), 32'(e.g));
        chk("timeout", 32'(bus.timeout), 32'(e.t));
        chk("gnt_valid", 32'(bus.gnt_valid), 32'(e.g != 8'h00));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] r;
    bus.req  = '0;
    bus.done = 1'b0;
    #2;
    chk("init_grant", 32'(bus.grant), 32'h0);
    chk("init_gnt_valid", 32'(bus.gnt_valid), 32'h0);
    chk("init_timeout", 32'(bus.timeout), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, release by done, then pointer moved past bit 2
    step(8'h04, 1'b0);  chk("single_grant", 32'(bus.grant), 32'h04);
    step(8'h04, 1'b1);  chk("single_release", 32'(bus.grant), 32'h00);
    step(8'hFF, 1'b0);  chk("after_single", 32'(bus.grant), 32'h08);
    step(8'hFF, 1'b1);

    // Asynchronous reset during a grant
    step(8'h04, 1'b0);  chk("pre_rst_grant", 32'(bus.grant), 32'h04);
    do_reset();
    step(8'hFF, 1'b0);  chk("post_rst_grant", 32'(bus.grant), 32'h01);
    step(8'hFF, 1'b1);

    // Full rotation from a clean pointer
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
      chk("rotation", 32'(bus.grant), 32'(1 << (i % 8)));
      step(8'hFF, 1'b1);
      chk("rotation_idle", 32'(bus.grant), 32'h0);
    end

    // Wrap between bits 7 and 0
    step(8'h81, 1'b0);  chk("wrap_a", 32'(bus.grant), 32'h80);
    step(8'h81, 1'b1);
    step(8'h81, 1'b0);  chk("wrap_b", 32'(bus.grant), 32'h01);
    step(8'h81, 1'b1);
    step(8'h81, 1'b0);  chk("wrap_c", 32'(bus.grant), 32'h80);
    step(8'h81, 1'b1);

    // Watchdog: 16 grant cycles then forced release with a pulse
    step(8'h10, 1'b0);  chk("wd_grant", 32'(bus.grant), 32'h10);
    for (int i = 0; i < TMO - 1; i++) step(8'h10, 1'b0);
    chk("wd_held", 32'(bus.grant), 32'h10);
    step(8'h10, 1'b0);
    chk("wd_release", 32'(bus.grant), 32'h00);
    chk("wd_pulse", 32'(bus.timeout), 32'h1);
    step(8'h30, 1'b0);
    chk("wd_pulse_end", 32'(bus.timeout), 32'h0);
    chk("wd_ptr5", 32'(bus.grant), 32'h20);
    step(8'h30, 1'b1);

    // done on the final watchdog cycle suppresses the pulse
    step(8'h10, 1'b0);  chk("col_grant", 32'(bus.grant), 32'h10);
    for (int i = 0; i < TMO - 1; i++) step(8'h10, 1'b0);
    step(8'h10, 1'b1);
    chk("col_release", 32'(bus.grant), 32'h00);
    chk("col_no_pulse", 32'(bus.timeout), 32'h0);

    // Withdrawal mid-grant, then done while idle
    step(8'h10, 1'b0);  chk("wdraw_grant", 32'(bus.grant), 32'h10);
    step(8'h10, 1'b0);
    step(8'h00, 1'b0);  chk("wdraw_release", 32'(bus.grant), 32'h00);
    step(8'h00, 1'b1);  chk("idle_done", 32'(bus.grant), 32'h00);

    // Randomized traffic with occasional resets
    r = 8'h00;
    for (int n = 0; n < 2000; n++) begin
      if (n % 500 == 250) do_reset();
      if ($urandom_range(0, 3) == 0)
        r = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      step(r, ($urandom_range(0, 7) == 0));
    end

    step(8'h00, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
